instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 136 +++++++++++++
 tb/tb_instr_fetch.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-request memory handshake, instruction register and next-PC select.
// Optional misaligned-target halt is compiled in with the FETCH_MISALIGN_EN macro.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        iCLK,
  input  logic        iRSTn,
  input  logic        iStall,
  input  logic [1:0]  iOrigPC,
  input  logic        iBranchTaken,
  input  logic [31:0] iImm,
  input  logic [31:0] iJalrTarget,
  output logic        oIMemReq,
  output logic [31:0] oIMemAddr,
  input  logic        iIMemAck,
  input  logic [31:0] iIMemData,
  output logic [31:0] oInstr,
  output logic [31:0] oPC,
  output logic [31:0] oPCPlus4,
  output logic        oInstrValid,
  output logic        oMisalign
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    VALID = 2'b10,
    HALT  = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        req_q, valid_q;
  logic [31:0] pc_plus4_s;
  logic [31:0] target_s;

  // Next-PC candidate selected by the control unit; all arithmetic wraps at 32 bits.
  always_comb begin
    pc_plus4_s = pc_q + 32'd4;
    target_s   = pc_plus4_s;
    case (iOrigPC)
      2'b00: target_s = pc_plus4_s;
      2'b01: begin
        if (iBranchTaken) begin
          target_s = pc_q + iImm;
        end else begin
          target_s = pc_plus4_s;
        end
      end
      2'b10: target_s = pc_q + iImm;
      2'b11: target_s = iJalrTarget & 32'hFFFF_FFFE;
      default: target_s = pc_plus4_s;
    endcase
  end

  // Fetch FSM next-state, PC and instruction-register update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (iIMemAck) begin
          instr_d = iIMemData;
          state_d = VALID;
        end else begin
          state_d = REQ;
        end
      end
      VALID: begin
        if (!iStall) begin
`ifdef FETCH_MISALIGN_EN
          pc_d = target_s;
          if (target_s[1:0] != 2'b00) begin
            state_d = HALT;
          end else begin
            state_d = REQ;
          end
`else
          pc_d    = target_s & 32'hFFFF_FFFC;
          state_d = REQ;
`endif
        end else begin
          state_d = VALID;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // State, PC, instruction register and registered status flags.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= (state_d == REQ);
      valid_q <= (state_d == VALID);
    end
  end

`ifdef FETCH_MISALIGN_EN
  logic misalign_q;

  // Sticky misalign flag, cleared only by reset.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= (state_d == HALT);
    end
  end

  assign oMisalign = misalign_q;
`else
  assign oMisalign = 1'b0;
`endif

  assign oIMemReq    = req_q;
  assign oIMemAddr   = pc_q;
  assign oPC         = pc_q;
  assign oPCPlus4    = pc_plus4_s;
  assign oInstr      = instr_q;
  assign oInstrValid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: scoreboard of issued (PC, instruction) pairs plus a wrap-around instance.
`timescale 1ns/1ps
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [1:0]  orig;
  logic        taken;
  logic [31:0] imm, jalr;
  logic        ack;
  logic [31:0] data;
  logic        req, valid, mis;
  logic [31:0] addr, instr, pc, pc4;
  logic        w_req, w_valid, w_mis;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int t0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  // Free-running cycle counter for issue-rate checks.
  always @(posedge clk) cyc <= cyc + 1;

  instr_fetch dut (
    .iCLK(clk), .iRSTn(rst_n), .iStall(stall), .iOrigPC(orig), .iBranchTaken(taken),
    .iImm(imm), .iJalrTarget(jalr), .oIMemReq(req), .oIMemAddr(addr), .iIMemAck(ack),
    .iIMemData(data), .oInstr(instr), .oPC(pc), .oPCPlus4(pc4), .oInstrValid(valid),
    .oMisalign(mis)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .iCLK(clk), .iRSTn(rst_n), .iStall(stall), .iOrigPC(orig), .iBranchTaken(taken),
    .iImm(imm), .iJalrTarget(jalr), .oIMemReq(w_req), .oIMemAddr(w_addr), .iIMemAck(ack),
    .iIMemData(data), .oInstr(w_instr), .oPC(w_pc), .oPCPlus4(w_pc4), .oInstrValid(w_valid),
    .oMisalign(w_mis)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // From REQ: wait 'waits' cycles, ack, check the issued pair, then stall 'stalls' cycles.
  task automatic issue(input logic [31:0] d, input int waits, input int stalls);
    logic [31:0] a;
    logic [63:0] e;
    a = addr;
    chk("req_in_REQ", {31'd0, req}, 32'd1);
    for (int i = 0; i < waits; i++) begin
      ack = 1'b0;
      tick();
      chk("addr_stable", addr, a);
      chk("req_wait", {31'd0, req}, 32'd1);
      chk("valid_wait", {31'd0, valid}, 32'd0);
    end
    ack  = 1'b1;
    data = d;
    sb_q.push_back({a, d});
    tick();
    ack  = 1'b0;
    data = 32'h0;
    chk("valid_issue", {31'd0, valid}, 32'd1);
    chk("req_in_VALID", {31'd0, req}, 32'd0);
    e = sb_q.pop_front();
    chk("sb_pc", pc, e[63:32]);
    chk("sb_instr", instr, e[31:0]);
    for (int i = 0; i < stalls; i++) begin
      stall = 1'b1;
      tick();
      chk("stall_valid", {31'd0, valid}, 32'd1);
      chk("stall_pc", pc, e[63:32]);
      chk("stall_instr", instr, e[31:0]);
      chk("stall_req", {31'd0, req}, 32'd0);
    end
    stall = 1'b0;
  endtask

  // From VALID: leave with the given next-PC select and check the new fetch address.
  task automatic advance(input logic [1:0] o, input logic tk, input logic [31:0] im,
                         input logic [31:0] jt, input logic [31:0] exp);
    orig  = o;
    taken = tk;
    imm   = im;
    jalr  = jt;
    stall = 1'b0;
    tick();
    chk("next_pc", pc, exp);
    chk("next_addr", addr, exp);
    chk("next_req", {31'd0, req}, 32'd1);
    chk("next_valid", {31'd0, valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; orig = 2'b00; taken = 1'b0;
    imm = 32'h0; jalr = 32'h0; ack = 1'b0; data = 32'h0;
    tick();
    tick();
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_mis", {31'd0, mis}, 32'd0);
    chk("rst_w_pc", w_pc, 32'hFFFF_FFFC);
    rst_n = 1'b1;
    tick();
    chk("first_req", {31'd0, req}, 32'd1);
    chk("first_addr", addr, 32'h0040_0000);
    chk("first_pc4", pc4, 32'h0040_0004);

    // Sequential fetch, same-cycle ack, wrap instance in lockstep
    issue(32'h0000_0013, 0, 0);
    t0 = cyc;
    chk("w_issue_pc", w_pc, 32'hFFFF_FFFC);
    chk("w_issue_pc4", w_pc4, 32'h0000_0000);
    chk("w_issue_valid", {31'd0, w_valid}, 32'd1);
    advance(2'b00, 1'b0, 32'h0, 32'h0, 32'h0040_0004);
    chk("w_wrap_pc", w_pc, 32'h0000_0000);
    issue(32'h0000_0013, 0, 0);
    chk("issue_gap", cyc - t0, 32'd2);
    t0 = cyc;
    advance(2'b00, 1'b0, 32'h0, 32'h0, 32'h0040_0008);
    issue(32'h0000_0013, 0, 0);
    chk("issue_gap2", cyc - t0, 32'd2);

    // Wait states then stall
    advance(2'b00, 1'b0, 32'h0, 32'h0, 32'h0040_000C);
    issue(32'h00A0_0093, 3, 4);
    advance(2'b00, 1'b0, 32'h0, 32'h0, 32'h0040_0010);
    issue(32'h1234_5678, 0, 0);

    // Control transfers
    advance(2'b01, 1'b1, 32'hFFFF_FFF0, 32'h0, 32'h0040_0000);
    issue(32'h0000_0063, 0, 0);
    advance(2'b11, 1'b0, 32'h0, 32'h0040_0011, 32'h0040_0010);
    issue(32'h0000_0063, 1, 0);
    advance(2'b01, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h0040_0014);
    issue(32'h0000_0067, 0, 1);
    advance(2'b11, 1'b1, 32'h0, 32'h0040_0021, 32'h0040_0020);
    issue(32'h0000_006F, 0, 0);
    advance(2'b10, 1'b0, 32'h0000_0008, 32'h0, 32'h0040_0028);

    // Reset while a request is outstanding, ack pulsed during and after reset
    ack = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, 32'h0040_0000);
    chk("async_rst_req", {31'd0, req}, 32'd0);
    chk("async_rst_instr", instr, 32'h0000_0013);
    ack  = 1'b1;
    data = 32'hDEAD_BEEF;
    tick();
    tick();
    chk("rst_hold_instr", instr, 32'h0000_0013);
    rst_n = 1'b1;
    tick();
    chk("post_rst_instr", instr, 32'h0000_0013);
    chk("post_rst_valid", {31'd0, valid}, 32'd0);
    chk("post_rst_pc", pc, 32'h0040_0000);
    chk("post_rst_req", {31'd0, req}, 32'd1);
    chk("sb_drained", sb_q.size(), 32'd0);
    ack  = 1'b0;
    data = 32'h0;

    // Misaligned jal target
    issue(32'h0020_006F, 0, 0);
    orig = 2'b10;
    imm  = 32'h0000_0002;
    tick();
`ifdef FETCH_MISALIGN_EN
    chk("halt_mis", {31'd0, mis}, 32'd1);
    chk("halt_pc", pc, 32'h0040_0002);
    chk("halt_req", {31'd0, req}, 32'd0);
    chk("halt_valid", {31'd0, valid}, 32'd0);
    ack  = 1'b1;
    data = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_hold_mis", {31'd0, mis}, 32'd1);
      chk("halt_hold_valid", {31'd0, valid}, 32'd0);
      chk("halt_hold_req", {31'd0, req}, 32'd0);
      chk("halt_hold_instr", instr, 32'h0020_006F);
    end
    ack = 1'b0;
`else
    chk("align_mis", {31'd0, mis}, 32'd0);
    chk("align_pc", pc, 32'h0040_0000);
    chk("align_req", {31'd0, req}, 32'd1);
    chk("align_valid", {31'd0, valid}, 32'd0);
    orig = 2'b00;
    imm  = 32'h0;
    issue(32'h0010_0073, 0, 0);
    chk("align_mis_after", {31'd0, mis}, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
